// File: rtl/fetch_ctrl.sv
// Next-PC / fetch-enable sequencer: merges PC+4, decode redirects, stall and halt; npc and ifu_en are combinational (0 added cycles).
// Backpressure: stall/halt freeze fetch (npc holds pc_in); a redirect seen while frozen is held and delivered on the first enabled cycle.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          IMEM_WORDS = 4096,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_in,
  input  logic             stall,
  input  logic             redir_valid,
  input  logic [31:0]      redir_target,
  input  logic             halt_req,
  input  logic             resume,
  output logic [31:0]      npc,
  output logic             ifu_en,
  output logic             redir_pending,
  output logic [1:0]       state,
  output logic             addr_err,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } state_t;

  // One past the last legal byte address; 33 bits so the bound cannot wrap.
  localparam logic [32:0] WIN_END = {1'b0, RESET_PC} + 33'(4 * IMEM_WORDS);

  state_t      state_q;
  state_t      state_d;
  logic        pend_v;
  logic [31:0] pend_tgt;
  logic        en_raw;
  logic        del;
  logic        bad;
  logic [31:0] tgt;

  always_comb begin
    en_raw = (state_q == RUN) & ~stall & ~halt_req;
    tgt    = redir_valid ? redir_target : pend_tgt;
    del    = en_raw & (redir_valid | pend_v);
    bad    = del & ((tgt[1:0] != 2'b00) | (tgt < RESET_PC) | ({1'b0, tgt} >= WIN_END));
    ifu_en = 1'b0;
    npc    = RESET_PC;
    if (reset) begin
      ifu_en = en_raw & ~bad;
      if (del)
        npc = tgt;
      else if (en_raw)
        npc = pc_in + 32'd4;
      else
        npc = pc_in;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (halt_req)
          state_d = HALT;
        else if (bad)
          state_d = ERR;
      end
      HALT: begin
        if (resume && !halt_req)
          state_d = RUN;
      end
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RUN;
      pend_v    <= 1'b0;
      pend_tgt  <= RESET_PC;
      addr_err  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (bad)
        addr_err <= 1'b1;
      // Latch and clear are exclusive: delivery needs en_raw, latching needs ~en_raw.
      if (state_q != ERR) begin
        if (redir_valid && !en_raw) begin
          pend_v   <= 1'b1;
          pend_tgt <= redir_target;
        end else if (del && !bad) begin
          pend_v <= 1'b0;
        end
      end
      if (state_q == RUN && stall && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign redir_pending = pend_v;
  assign state         = state_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl (CNT_W=4 so counter saturation is reachable quickly).
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic        stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic        halt_req;
  logic        resume;
  logic [31:0] npc;
  logic        ifu_en;
  logic        redir_pending;
  logic [1:0]  state;
  logic        addr_err;
  logic [3:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  fetch_ctrl #(.RESET_PC(32'h0000_3000), .IMEM_WORDS(4096), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .stall(stall),
    .redir_valid(redir_valid), .redir_target(redir_target),
    .halt_req(halt_req), .resume(resume), .npc(npc), .ifu_en(ifu_en),
    .redir_pending(redir_pending), .state(state), .addr_err(addr_err),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are then driven at posedge+1 and outputs sampled at posedge+2.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; redir_valid = 0; redir_target = 32'h0; halt_req = 0; resume = 0;
  endtask

  task automatic pulse_reset();
    reset = 0;
    #1;
    checks++; if (ifu_en !== 1'b0) begin errors++; $display("FAIL rst_ifu_en got %b exp 0", ifu_en); end
    checks++; if (npc !== 32'h3000) begin errors++; $display("FAIL rst_npc got %h exp 00003000", npc); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_addr_err got %b exp 0", addr_err); end
    checks++; if (redir_pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b exp 0", redir_pending); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rst_stall_cnt got %0d exp 0", stall_cnt); end
    tick();
    reset = 1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    pc_in = 32'h3000;
    pulse_reset();
    checks++; if (ifu_en !== 1'b1) begin errors++; $display("FAIL run_ifu_en got %b exp 1", ifu_en); end
    checks++; if (npc !== 32'h3004) begin errors++; $display("FAIL run_npc got %h exp 00003004", npc); end
    tick();
    checks++; if (state !== 2'd0 || stall_cnt !== 4'd0) begin errors++; $display("FAIL run_state_cnt got %0d/%0d exp 0/0", state, stall_cnt); end
  endtask

  task automatic test_stall_redirect();
    pc_in = 32'h3004;
    stall = 1; redir_valid = 1; redir_target = 32'h3040;
    #1;
    checks++; if (ifu_en !== 1'b0 || npc !== 32'h3004) begin errors++; $display("FAIL stall_hold got en=%b npc=%h exp en=0 npc=00003004", ifu_en, npc); end
    tick();
    redir_valid = 0;
    #1;
    checks++; if (redir_pending !== 1'b1) begin errors++; $display("FAIL stall_pending got %b exp 1", redir_pending); end
    tick();
    tick();
    checks++; if (stall_cnt !== 4'd3) begin errors++; $display("FAIL stall_cnt3 got %0d exp 3", stall_cnt); end
    stall = 0;
    #1;
    checks++; if (npc !== 32'h3040 || ifu_en !== 1'b1) begin errors++; $display("FAIL stall_deliver got npc=%h en=%b exp 00003040/1", npc, ifu_en); end
    tick();
    pc_in = 32'h3040;
    #1;
    checks++; if (redir_pending !== 1'b0) begin errors++; $display("FAIL stall_cleared got %b exp 0", redir_pending); end
    checks++; if (npc !== 32'h3044 || stall_cnt !== 4'd3) begin errors++; $display("FAIL stall_after got npc=%h cnt=%0d exp 00003044/3", npc, stall_cnt); end
  endtask

  task automatic test_fresh_beats_pending();
    stall = 1; redir_valid = 1; redir_target = 32'h3040;
    tick();
    stall = 0; redir_target = 32'h3080;
    #1;
    checks++; if (npc !== 32'h3080 || ifu_en !== 1'b1) begin errors++; $display("FAIL fresh_npc got npc=%h en=%b exp 00003080/1", npc, ifu_en); end
    tick();
    redir_valid = 0; pc_in = 32'h3080;
    #1;
    checks++; if (redir_pending !== 1'b0 || npc !== 32'h3084) begin errors++; $display("FAIL fresh_clear got pend=%b npc=%h exp 0/00003084", redir_pending, npc); end
    checks++; if (stall_cnt !== 4'd4) begin errors++; $display("FAIL fresh_cnt got %0d exp 4", stall_cnt); end
  endtask

  task automatic test_halt();
    halt_req = 1;
    #1;
    checks++; if (ifu_en !== 1'b0 || npc !== 32'h3080) begin errors++; $display("FAIL halt_req_comb got en=%b npc=%h exp 0/00003080", ifu_en, npc); end
    tick();
    halt_req = 0;
    #1;
    checks++; if (state !== 2'd1 || ifu_en !== 1'b0) begin errors++; $display("FAIL halt_state got st=%0d en=%b exp 1/0", state, ifu_en); end
    halt_req = 1; resume = 1;
    tick();
    halt_req = 0;
    #1;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL halt_wins got %0d exp 1", state); end
    tick();
    resume = 0;
    #1;
    checks++; if (state !== 2'd0 || ifu_en !== 1'b1 || npc !== 32'h3084) begin errors++; $display("FAIL resume got st=%0d en=%b npc=%h exp 0/1/00003084", state, ifu_en, npc); end
    pc_in = 32'hFFFF_FFFC;
    #1;
    checks++; if (npc !== 32'h0) begin errors++; $display("FAIL pc_wrap got %h exp 00000000", npc); end
    pc_in = 32'h3084;
    // Redirect in the same cycle as halt_req is held across HALT.
    halt_req = 1; redir_valid = 1; redir_target = 32'h3100;
    tick();
    halt_req = 0; redir_valid = 0;
    #1;
    checks++; if (state !== 2'd1 || redir_pending !== 1'b1) begin errors++; $display("FAIL halt_latch got st=%0d pend=%b exp 1/1", state, redir_pending); end
    resume = 1;
    tick();
    resume = 0;
    #1;
    checks++; if (npc !== 32'h3100 || ifu_en !== 1'b1) begin errors++; $display("FAIL halt_deliver got npc=%h en=%b exp 00003100/1", npc, ifu_en); end
    tick();
  endtask

  task automatic test_bad_target();
    pc_in = 32'h3100;
    redir_valid = 1; redir_target = 32'h3002;
    #1;
    checks++; if (ifu_en !== 1'b0) begin errors++; $display("FAIL misalign_en got %b exp 0", ifu_en); end
    tick();
    redir_target = 32'h3200;
    #1;
    checks++; if (state !== 2'd2 || addr_err !== 1'b1 || ifu_en !== 1'b0) begin errors++; $display("FAIL misalign_err got st=%0d err=%b en=%b exp 2/1/0", state, addr_err, ifu_en); end
    tick();
    redir_valid = 0;
    tick();
    checks++; if (state !== 2'd2 || redir_pending !== 1'b0 || npc !== 32'h3100) begin errors++; $display("FAIL err_absorb got st=%0d pend=%b npc=%h exp 2/0/00003100", state, redir_pending, npc); end
    pulse_reset();
    redir_valid = 1; redir_target = 32'h6FFC;
    #1;
    checks++; if (ifu_en !== 1'b1 || npc !== 32'h6FFC) begin errors++; $display("FAIL last_word got en=%b npc=%h exp 1/00006FFC", ifu_en, npc); end
    tick();
    redir_target = 32'h7000;
    #1;
    checks++; if (ifu_en !== 1'b0) begin errors++; $display("FAIL oow_en got %b exp 0", ifu_en); end
    tick();
    redir_valid = 0;
    #1;
    checks++; if (state !== 2'd2 || addr_err !== 1'b1) begin errors++; $display("FAIL oow_err got st=%0d err=%b exp 2/1", state, addr_err); end
    pulse_reset();
    redir_valid = 1; redir_target = 32'h2FFC;
    tick();
    redir_valid = 0;
    #1;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL below_win got %0d exp 2", state); end
    pulse_reset();
  endtask

  task automatic test_saturation();
    pc_in = 32'h3000;
    stall = 1;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat15 got %0d exp 15", stall_cnt); end
    for (int i = 0; i < 5; i++) tick();
    checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat20 got %0d exp 15", stall_cnt); end
    redir_valid = 1; redir_target = 32'h3200;
    tick();
    redir_valid = 0;
    #1;
    checks++; if (redir_pending !== 1'b1) begin errors++; $display("FAIL sat_pend got %b exp 1", redir_pending); end
    pulse_reset();
    stall = 0;
    #1;
    checks++; if (npc !== 32'h3004 || ifu_en !== 1'b1 || redir_pending !== 1'b0) begin errors++; $display("FAIL restart got npc=%h en=%b pend=%b exp 00003004/1/0", npc, ifu_en, redir_pending); end
  endtask

  initial begin
    reset = 0;
    pc_in = 32'h3000;
    idle_inputs();
    tick();
    test_reset();
    test_stall_redirect();
    test_fresh_beats_pending();
    test_halt();
    test_bad_target();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
